cfg_apb_bridge: RTL
===================

Name: cfg_apb_bridge

Overview:
Host-side front end of the uCode sequencer config port. Terminates an APB3 slave transfer from the SoC interconnect. Converts it into a single req/gnt/rvalid transaction on the config interface that the config unit consumes. Adds address-window and alignment checking and a response timeout, reported through pslverr.

Parameters:
APB_ADDR_WIDTH, 32, width of paddr.
CFG_ADDR_WIDTH, 16, width of cfg_addr_t; the low bits of paddr forwarded to the config port.
WINDOW_BASE, 32'h1A40_0000, base of the accelerator window; bits [APB_ADDR_WIDTH-1:CFG_ADDR_WIDTH] must match.
TIMEOUT_CYCLES, 15, maximum cycles waited for gnt or rvalid before an error (>=1).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
psel_i  in  1  APB select
penable_i  in  1  APB access phase
pwrite_i  in  1  1 = write
paddr_i  in  APB_ADDR_WIDTH  byte address
pwdata_i  in  32  write data
prdata_o  out  32  read data, registered
pready_o  out  1  transfer complete
pslverr_o  out  1  error, valid with pready_o
cfg_req_o  out  1  config request
cfg_gnt_i  in  1  config grant, same cycle as req
cfg_wen_o  out  1  config write-enable, active-low: 0 = write, 1 = read
cfg_addr_o  out  cfg_addr_t  paddr_i[CFG_ADDR_WIDTH-1:0] as captured
cfg_wdata_o  out  word_t  captured pwdata
cfg_rdata_i  in  word_t  config read data
cfg_rvalid_i  in  1  config read data valid; one cycle after gnt of a read

Behaviour:
- Clock and reset: single clock clk_i. Asynchronous active-low reset rst_ni.
- Reset values: state IDLE; cfg_req_o=0; pready_o=0; pslverr_o=0; prdata_o=0; captured addr/wdata/dir=0; timeout counter=0.
- Async reset mid-transfer: cfg_req_o and pready_o drop immediately; no cfg transaction is replayed.
- IDLE:
  - Trigger is psel_i & !penable_i (setup phase). Capture paddr, pwdata, pwrite. Clear the counter.
  - If the upper address bits do not equal WINDOW_BASE upper bits, or paddr[1:0] != 0: go to DONE with err=1. No cfg_req is issued.
  - Otherwise go to REQ.
- REQ:
  - Drive cfg_req_o=1 with cfg_wen_o = !pwrite_q and addr/wdata from the captured registers. Hold them stable.
  - gnt & write: go to DONE, err=0.
  - gnt & read: go to RD_WAIT, counter cleared.
  - No gnt: counter++. When the counter reaches TIMEOUT_CYCLES, go to DONE with err=1.
- RD_WAIT:
  - cfg_req_o=0.
  - cfg_rvalid_i: register cfg_rdata_i into prdata_o, then go to DONE with err=0. The value 32'hdeadda7a is passed through unaltered and is not an error.
  - Otherwise counter++. At TIMEOUT_CYCLES: prdata_o=0, go to DONE with err=1.
- DONE:
  - pready_o = psel_i & penable_i (combinational from state). pslverr_o = err_q & pready_o.
  - On pready_o: go to IDLE.
  - If psel_i=0 (abandoned transfer): go to IDLE without pready_o.
- pready_o is 0 in every state other than DONE; this inserts wait states.
- Latency, with config-unit responses, setup phase at T0:
  - Write: REQ/gnt at T1, pready at T2. Total 3 cycles, 1 wait state.
  - Read: gnt at T1, rvalid at T2, pready at T3. Total 4 cycles.
- cfg_rvalid_i outside RD_WAIT and cfg_gnt_i outside REQ are ignored.
- prdata_o holds its last value for writes and errors; it is set to 0 only on a read timeout.
- Back-to-back transfers: a setup phase in the cycle after DONE is accepted normally; no idle gap is needed beyond APB's own setup cycle.
- Counter width: $clog2(TIMEOUT_CYCLES+1); saturates, never wraps.

Decomposition:
- Existing types word_t and cfg_addr_t come from pkg_common.
- Add WINDOW_BASE as ACCEL_APB_BASE_ADDR in pkg_memory_mapping.
- Add CFG_ERR_PATTERN = 32'hdeadda7a to pkg_ucode_sequencer. The config unit and the bench share this constant.
- The state enum (IDLE, REQ, RD_WAIT, DONE) stays local.
- No sub-module; the timeout counter is inline.

Test Plan:
- Write: paddr=WINDOW_BASE+32'h1000, pwdata=32'h0000_0005, gnt in the first REQ cycle -> single-cycle cfg_req with wen=0, addr=16'h1000, wdata=5; pready at T2, pslverr=0.
- Read: paddr=WINDOW_BASE+32'h2004, gnt immediate, rvalid next cycle with rdata=32'hCAFE_0001 -> cfg_wen=1, addr=16'h2004; pready at T3, prdata=32'hCAFE_0001, pslverr=0.
- Out-of-window: paddr=32'h1A50_0000, and separately misaligned paddr=WINDOW_BASE+2 -> no cfg_req ever asserted; pready one cycle after setup, pslverr=1.
- Timeout: hold gnt=0 (write), then separately gnt=1 with rvalid=0 (read) -> pready after 15 counted cycles with pslverr=1; prdata=0 on the read case.
- Reset: assert rst_ni low during RD_WAIT -> cfg_req_o, pready_o=0 immediately; after release a fresh read completes in 4 cycles with correct data.
- Back-to-back: write then read with no idle gap, plus a stray rvalid during IDLE -> both complete with correct latencies; stray rvalid does not change prdata.

Source files
------------

// File: rtl/cfg_apb_bridge_pkg.sv
// Shared types and constants for the uCode sequencer config-port bridge.
// Holds the word/address types, the accelerator APB window base and the config error pattern.
package cfg_apb_bridge_pkg;

   localparam int unsigned WORD_W     = 32;
   localparam int unsigned CFG_ADDR_W = 16;

   typedef logic [WORD_W-1:0]     word_t;
   typedef logic [CFG_ADDR_W-1:0] cfg_addr_t;

   localparam logic [31:0] ACCEL_APB_BASE_ADDR = 32'h1A40_0000;

   // The config unit returns this on internal faults; the bridge treats it as ordinary data.
   localparam word_t CFG_ERR_PATTERN = 32'hdeadda7a;

   function automatic int unsigned timeout_cnt_width(input int unsigned cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/cfg_apb_bridge_if.sv
// Bus bundles for the bridge: an APB3 completer-side interface and the req/gnt/rvalid config port.
// The bridge uses apb.slave and cfg.master; the bench takes the opposite modports.
interface cfg_apb_bridge_apb_if #(
   parameter int unsigned ADDR_WIDTH = 32
);
   import cfg_apb_bridge_pkg::*;

   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   word_t                 pwdata;
   word_t                 prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );

endinterface

interface cfg_apb_bridge_cfg_if;
   import cfg_apb_bridge_pkg::*;

   logic      req;
   logic      gnt;
   logic      wen;
   cfg_addr_t addr;
   word_t     wdata;
   word_t     rdata;
   logic      rvalid;

   modport master (
      output req, wen, addr, wdata,
      input  gnt, rdata, rvalid
   );

   modport slave (
      input  req, wen, addr, wdata,
      output gnt, rdata, rvalid
   );

endinterface

// File: rtl/cfg_apb_bridge.sv
// APB3 completer that turns each transfer into one req/gnt/rvalid config transaction,
// with window/alignment checking and a grant/response timeout reported via pslverr.
module cfg_apb_bridge
   import cfg_apb_bridge_pkg::*;
#(
   parameter int unsigned                APB_ADDR_WIDTH = 32,
   parameter int unsigned                CFG_ADDR_WIDTH = CFG_ADDR_W,
   parameter logic [APB_ADDR_WIDTH-1:0]  WINDOW_BASE    = APB_ADDR_WIDTH'(ACCEL_APB_BASE_ADDR),
   parameter int unsigned                TIMEOUT_CYCLES = 15
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   cfg_apb_bridge_apb_if.slave    apb,
   cfg_apb_bridge_cfg_if.master   cfg
);

   localparam int unsigned CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RD_WAIT,
      DONE
   } state_t;

   state_t           state_q;
   logic             req_q;
   logic             err_q;
   logic             write_q;
   cfg_addr_t        addr_q;
   word_t            wdata_q;
   word_t            prdata_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_inc;
   logic             addr_ok;
   logic             setup;

   assign setup = apb.psel && !apb.penable;

   assign addr_ok = (apb.paddr[APB_ADDR_WIDTH-1:CFG_ADDR_WIDTH] ==
                     WINDOW_BASE[APB_ADDR_WIDTH-1:CFG_ADDR_WIDTH]) &&
                    (apb.paddr[1:0] == 2'b00);

   // Saturating so a stuck counter can never wrap back below the limit.
   always_comb begin
      cnt_inc = cnt_q;
      if (cnt_q != TIMEOUT_LIM) begin
         cnt_inc = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         req_q    <= 1'b0;
         err_q    <= 1'b0;
         write_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         prdata_q <= '0;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (setup) begin
                  addr_q  <= cfg_addr_t'(apb.paddr[CFG_ADDR_WIDTH-1:0]);
                  wdata_q <= apb.pwdata;
                  write_q <= apb.pwrite;
                  cnt_q   <= '0;
                  if (addr_ok) begin
                     state_q <= REQ;
                     req_q   <= 1'b1;
                     err_q   <= 1'b0;
                  end else begin
                     state_q <= DONE;
                     err_q   <= 1'b1;
                  end
               end
            end

            REQ: begin
               if (cfg.gnt) begin
                  req_q <= 1'b0;
                  cnt_q <= '0;
                  if (write_q) begin
                     state_q <= DONE;
                     err_q   <= 1'b0;
                  end else begin
                     state_q <= RD_WAIT;
                  end
               end else begin
                  cnt_q <= cnt_inc;
                  if (cnt_inc == TIMEOUT_LIM) begin
                     req_q   <= 1'b0;
                     state_q <= DONE;
                     err_q   <= 1'b1;
                  end
               end
            end

            RD_WAIT: begin
               if (cfg.rvalid) begin
                  prdata_q <= cfg.rdata;
                  err_q    <= 1'b0;
                  state_q  <= DONE;
               end else begin
                  cnt_q <= cnt_inc;
                  if (cnt_inc == TIMEOUT_LIM) begin
                     prdata_q <= '0;
                     err_q    <= 1'b1;
                     state_q  <= DONE;
                  end
               end
            end

            DONE: begin
               // Leaves on completion or when the requester drops psel mid-transfer.
               if (!apb.psel || apb.penable) begin
                  state_q <= IDLE;
               end
            end

            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign cfg.req     = req_q;
   assign cfg.wen     = !write_q;
   assign cfg.addr    = addr_q;
   assign cfg.wdata   = wdata_q;

   assign apb.prdata  = prdata_q;
   assign apb.pready  = (state_q == DONE) && apb.psel && apb.penable;
   assign apb.pslverr = err_q && apb.pready;

endmodule
